// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, one-hot T-states and control-word bit positions shared by the sequencer and its bench
package cpu_ctrl_pkg;
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_JMP = 4'h3;
    localparam logic [3:0] OP_OUT = 4'he;
    localparam logic [3:0] OP_HLT = 4'hf;
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;
    localparam int CW_W       = 13;
    localparam int CW_PC_INC  = 0;
    localparam int CW_PC_EN   = 1;
    localparam int CW_PC_LD   = 2;
    localparam int CW_MAR_LD  = 3;
    localparam int CW_RAM_EN  = 4;
    localparam int CW_IR_LD   = 5;
    localparam int CW_IR_EN   = 6;
    localparam int CW_ACC_LD  = 7;
    localparam int CW_ACC_EN  = 8;
    localparam int CW_B_LD    = 9;
    localparam int CW_ALU_EN  = 10;
    localparam int CW_ALU_SUB = 11;
    localparam int CW_OUT_LD  = 12;
endpackage

// File: rtl/t_state_ring.sv
// t_state_ring: one-hot T1..T6 ring; hold freezes it, restart forces T1 on the next edge
module t_state_ring
    import cpu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       restart,
    output logic [5:0] t_state
);
    logic [5:0] t_d, t_q;
    always_comb t_d = hold ? t_q : restart ? T1 : {t_q[4:0], t_q[5]};
    always_ff @(posedge clk or posedge rst)
        if (rst) t_q <= T1;
        else     t_q <= t_d;
    assign t_state = t_q;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute microcode decode from T-state and opcode, plus the sticky halted flag
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter bit EARLY_END = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    output logic       pc_inc,
    output logic       pc_en,
    output logic       pc_ld,
    output logic       mar_ld,
    output logic       ram_en,
    output logic       ir_ld,
    output logic       ir_en,
    output logic       acc_ld,
    output logic       acc_en,
    output logic       b_ld,
    output logic       alu_en,
    output logic       alu_sub,
    output logic       out_ld,
    output logic       halt,
    output logic [5:0] t_state
);
    logic [5:0] t;
    logic [CW_W-1:0] cw, cw_g;
    logic halted_d, halted_q;
    logic lda, add, sub, jmp, out, hlt, mem, arith, restart;
    assign lda   = opcode == OP_LDA;
    assign add   = opcode == OP_ADD;
    assign sub   = opcode == OP_SUB;
    assign jmp   = opcode == OP_JMP;
    assign out   = opcode == OP_OUT;
    assign hlt   = opcode == OP_HLT;
    assign mem   = lda | add | sub;
    assign arith = add | sub;
    assign restart = EARLY_END && t[3] && !(mem || hlt);
    t_state_ring u_ring (
        .clk     (clk),
        .rst     (rst),
        .hold    (halted_q),
        .restart (restart),
        .t_state (t)
    );
    always_comb halted_d = halted_q | (t[3] & hlt);
    always_ff @(posedge clk or posedge rst)
        if (rst) halted_q <= 1'b0;
        else     halted_q <= halted_d;
    always_comb begin
        cw             = '0;
        cw[CW_PC_INC]  = t[1];
        cw[CW_PC_EN]   = t[0];
        cw[CW_PC_LD]   = t[3] & jmp;
        cw[CW_MAR_LD]  = t[0] | (t[3] & mem);
        cw[CW_RAM_EN]  = t[2] | (t[4] & mem);
        cw[CW_IR_LD]   = t[2];
        cw[CW_IR_EN]   = t[3] & (mem | jmp);
        cw[CW_ACC_LD]  = (t[4] & lda) | (t[5] & arith);
        cw[CW_ACC_EN]  = t[3] & out;
        cw[CW_B_LD]    = t[4] & arith;
        cw[CW_ALU_EN]  = t[5] & arith;
        cw[CW_ALU_SUB] = t[5] & sub;
        cw[CW_OUT_LD]  = t[3] & out;
        cw_g           = (rst || halted_q) ? '0 : cw;
    end
    assign pc_inc  = cw_g[CW_PC_INC];
    assign pc_en   = cw_g[CW_PC_EN];
    assign pc_ld   = cw_g[CW_PC_LD];
    assign mar_ld  = cw_g[CW_MAR_LD];
    assign ram_en  = cw_g[CW_RAM_EN];
    assign ir_ld   = cw_g[CW_IR_LD];
    assign ir_en   = cw_g[CW_IR_EN];
    assign acc_ld  = cw_g[CW_ACC_LD];
    assign acc_en  = cw_g[CW_ACC_EN];
    assign b_ld    = cw_g[CW_B_LD];
    assign alu_en  = cw_g[CW_ALU_EN];
    assign alu_sub = cw_g[CW_ALU_SUB];
    assign out_ld  = cw_g[CW_OUT_LD];
    assign halt    = !rst && (halted_q || (t[3] && hlt));
    assign t_state = t;
endmodule
